// File: rtl/retire_stage_pkg.sv
// Shared types for the commit path: the ROB exit packet seen by retire_stage.
// Widths here must match the PHYS_REG_SZ / ARCH_REG_SZ the retire stage is built with.
package retire_stage_pkg;

  localparam int unsigned RobWidth    = 2;
  localparam int unsigned RobPhysRegs = 64;
  localparam int unsigned RobArchRegs = 32;
  localparam int unsigned RobPrBits   = $clog2(RobPhysRegs);
  localparam int unsigned RobArBits   = $clog2(RobArchRegs);

  typedef struct packed {
    logic                 complete;
    logic [RobPrBits-1:0] T_new;
    logic [RobPrBits-1:0] T_old;
    logic [RobArBits-1:0] arch_reg;
    logic                 has_dest;
    logic                 mispredict;
    logic                 halt;
  } ROB_EXIT_PACKET;

endpackage

// File: rtl/retire_stage.sv
// In-order commit: retires the longest completed prefix of the ROB head window, frees T_old,
// keeps the architectural map, and sequences the mispredict-recovery pulse and sticky halt.
module retire_stage
  import retire_stage_pkg::*;
#(
  parameter int unsigned N               = RobWidth,
  parameter int unsigned PHYS_REG_SZ     = RobPhysRegs,
  parameter int unsigned ARCH_REG_SZ     = RobArchRegs,
  localparam int unsigned PR_BITS         = $clog2(PHYS_REG_SZ),
  localparam int unsigned AR_BITS         = $clog2(ARCH_REG_SZ),
  localparam int unsigned NUM_SCALAR_BITS = $clog2(N + 1)
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  ROB_EXIT_PACKET [N-1:0]                  rob_outputs,
  input  logic [NUM_SCALAR_BITS-1:0]              outputs_valid,
  output logic [NUM_SCALAR_BITS-1:0]              num_retiring,
  output logic [N-1:0]                            free_valid,
  output logic [N-1:0][PR_BITS-1:0]               free_regs,
  output logic [ARCH_REG_SZ-1:0][PR_BITS-1:0]     arch_map,
  output logic                                    rollback,
  output logic                                    halted,
  output logic [63:0]                             retired_count
);

  typedef enum logic [1:0] {StRun, StRecover, StHalted} state_e;

  state_e       state_q;
  logic [N-1:0] retire;
  logic         blocked;
  logic         take_halt;
  logic         take_mispredict;

  // A mispredict or halt entry retires itself but blocks everything younger.
  always_comb begin
    retire          = '0;
    num_retiring    = '0;
    take_halt       = 1'b0;
    take_mispredict = 1'b0;
    blocked         = reset || (state_q != StRun);
    for (int i = 0; i < N; i++) begin
      if (!blocked && (NUM_SCALAR_BITS'(i) < outputs_valid) && rob_outputs[i].complete) begin
        retire[i]       = 1'b1;
        num_retiring    = NUM_SCALAR_BITS'(i + 1);
        take_halt       = take_halt | rob_outputs[i].halt;
        take_mispredict = take_mispredict | rob_outputs[i].mispredict;
        blocked         = rob_outputs[i].mispredict | rob_outputs[i].halt;
      end else begin
        blocked = 1'b1;
      end
    end
  end

  always_comb begin
    free_valid = '0;
    free_regs  = '0;
    for (int i = 0; i < N; i++) begin
      free_valid[i] = retire[i] & rob_outputs[i].has_dest & (|rob_outputs[i].arch_reg);
      free_regs[i]  = rob_outputs[i].T_old;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StRun;
      rollback      <= 1'b0;
      halted        <= 1'b0;
      retired_count <= '0;
      for (int r = 0; r < ARCH_REG_SZ; r++) begin
        arch_map[r] <= PR_BITS'(r);
      end
    end else begin
      retired_count <= retired_count + 64'(num_retiring);
      // Ascending slot order so the youngest write to a shared arch_reg lands last.
      for (int i = 0; i < N; i++) begin
        if (free_valid[i]) begin
          arch_map[AR_BITS'(rob_outputs[i].arch_reg)] <= rob_outputs[i].T_new;
        end
      end
      case (state_q)
        StRun: begin
          if (take_halt) begin
            state_q <= StHalted;
            halted  <= 1'b1;
          end else if (take_mispredict) begin
            state_q  <= StRecover;
            rollback <= 1'b1;
          end
        end
        StRecover: begin
          state_q  <= StRun;
          rollback <= 1'b0;
        end
        StHalted: begin
          state_q <= StHalted;
        end
        default: begin
          state_q  <= StRun;
          rollback <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_retire_stage.sv
// Directed and random checks of retire_stage against a prefix-scan reference model (N = 2).
module tb_retire_stage;
  import retire_stage_pkg::*;

  localparam int unsigned N   = 2;
  localparam int unsigned PRB = RobPrBits;
  localparam int unsigned ARN = RobArchRegs;

  logic                        clock = 1'b0;
  logic                        reset;
  ROB_EXIT_PACKET [N-1:0]      rob_outputs;
  logic [1:0]                  outputs_valid;
  logic [1:0]                  num_retiring;
  logic [N-1:0]                free_valid;
  logic [N-1:0][PRB-1:0]       free_regs;
  logic [ARN-1:0][PRB-1:0]     arch_map;
  logic                        rollback;
  logic                        halted;
  logic [63:0]                 retired_count;

  int checks = 0;
  int errors = 0;

  int unsigned  m_map [ARN];
  logic [63:0]  m_count;
  bit           m_rollback;
  bit           m_halted;
  int           exp_n;
  logic [N-1:0] exp_free;
  int           halt_cycles;

  always #5 clock = ~clock;

  retire_stage #(
    .N           (N),
    .PHYS_REG_SZ (RobPhysRegs),
    .ARCH_REG_SZ (ARN)
  ) u_dut (
    .clock         (clock),
    .reset         (reset),
    .rob_outputs   (rob_outputs),
    .outputs_valid (outputs_valid),
    .num_retiring  (num_retiring),
    .free_valid    (free_valid),
    .free_regs     (free_regs),
    .arch_map      (arch_map),
    .rollback      (rollback),
    .halted        (halted),
    .retired_count (retired_count)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ROB_EXIT_PACKET pk(input int c, input int tn, input int to, input int ar,
                                        input int hd, input int mp, input int h);
    ROB_EXIT_PACKET p;
    p            = '0;
    p.complete   = (c != 0);
    p.T_new      = PRB'(tn);
    p.T_old      = PRB'(to);
    p.arch_reg   = RobArBits'(ar);
    p.has_dest   = (hd != 0);
    p.mispredict = (mp != 0);
    p.halt       = (h != 0);
    return p;
  endfunction

  function automatic ROB_EXIT_PACKET rand_pkt();
    return pk(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, RobPhysRegs - 1)),
              int'($urandom_range(0, RobPhysRegs - 1)), int'($urandom_range(0, 7)),
              ($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 7) == 0) ? 1 : 0,
              ($urandom_range(0, 39) == 0) ? 1 : 0);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ARN; r++) m_map[r] = r;
    m_count    = '0;
    m_rollback = 1'b0;
    m_halted   = 1'b0;
  endtask

  // Reference: count completed entries from the head, stopping after a mispredict or halt.
  task automatic predict();
    exp_n    = 0;
    exp_free = '0;
    if (!reset && !m_rollback && !m_halted) begin
      for (int i = 0; i < int'(outputs_valid); i++) begin
        if (!rob_outputs[i].complete) break;
        exp_n++;
        if (rob_outputs[i].has_dest && rob_outputs[i].arch_reg != 0) exp_free[i] = 1'b1;
        if (rob_outputs[i].mispredict || rob_outputs[i].halt) break;
      end
    end
  endtask

  task automatic check_cycle(input string tag);
    logic [ARN-1:0][PRB-1:0] em;
    #1;
    if (reset) model_reset();
    predict();
    check({tag, "_num"}, 256'(num_retiring), 256'(exp_n));
    check({tag, "_fv"}, 256'(free_valid), 256'(exp_free));
    for (int i = 0; i < N; i++) begin
      if (exp_free[i]) check({tag, "_freg"}, 256'(free_regs[i]), 256'(rob_outputs[i].T_old));
    end
    check({tag, "_rollback"}, 256'(rollback), 256'(m_rollback));
    check({tag, "_halted"}, 256'(halted), 256'(m_halted));
    check({tag, "_count"}, 256'(retired_count), 256'(m_count));
    for (int r = 0; r < ARN; r++) em[r] = PRB'(m_map[r]);
    check({tag, "_map"}, 256'(arch_map), 256'(em));
  endtask

  task automatic advance();
    bit h;
    bit m;
    predict();
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      h = 1'b0;
      m = 1'b0;
      for (int i = 0; i < exp_n; i++) begin
        if (exp_free[i]) m_map[rob_outputs[i].arch_reg] = rob_outputs[i].T_new;
        h |= rob_outputs[i].halt;
        m |= rob_outputs[i].mispredict;
      end
      m_count = m_count + 64'(exp_n);
      if (!m_halted) begin
        if (h) begin
          m_halted   = 1'b1;
          m_rollback = 1'b0;
        end else begin
          m_rollback = m;
        end
      end
    end
    @(negedge clock);
  endtask

  initial begin
    reset         = 1'b1;
    rob_outputs   = '0;
    outputs_valid = '0;
    model_reset();
    repeat (2) @(negedge clock);

    // Complete inputs during reset must not retire anything.
    rob_outputs[0] = pk(1, 10, 11, 2, 1, 0, 0);
    rob_outputs[1] = pk(1, 12, 13, 4, 1, 0, 0);
    outputs_valid  = 2'd2;
    check_cycle("in_reset");
    check("in_reset_num_const", 256'(num_retiring), 256'(0));
    @(negedge clock);
    reset         = 1'b0;
    rob_outputs   = '0;
    outputs_valid = 2'd0;
    check_cycle("idle");
    check("idle_map5", 256'(arch_map[5]), 256'(5));
    advance();

    // Full retire with a same-register pair: youngest write wins.
    rob_outputs[0] = pk(1, 40, 3, 3, 1, 0, 0);
    rob_outputs[1] = pk(1, 41, 40, 3, 1, 0, 0);
    outputs_valid  = 2'd2;
    check_cycle("full");
    check("full_num_const", 256'(num_retiring), 256'(2));
    check("full_fv_const", 256'(free_valid), 256'(2'b11));
    check("full_freg0_const", 256'(free_regs[0]), 256'(3));
    check("full_freg1_const", 256'(free_regs[1]), 256'(40));
    advance();
    outputs_valid = 2'd0;
    check_cycle("full_after");
    check("full_map3_const", 256'(arch_map[3]), 256'(41));
    check("full_count_const", 256'(retired_count), 256'(2));
    advance();

    rob_outputs[0] = pk(1, 33, 5, 5, 1, 0, 0);
    outputs_valid  = 2'd1;
    check_cycle("write5");
    advance();

    // Prefix stop, entries above outputs_valid, and an empty ROB.
    rob_outputs[0] = pk(0, 20, 21, 6, 1, 0, 0);
    rob_outputs[1] = pk(1, 22, 23, 7, 1, 0, 0);
    outputs_valid  = 2'd2;
    check_cycle("prefix");
    check("prefix_num_const", 256'(num_retiring), 256'(0));
    advance();
    outputs_valid = 2'd1;
    check_cycle("above_valid");
    check("above_valid_num_const", 256'(num_retiring), 256'(0));
    advance();
    rob_outputs[0] = pk(1, 20, 21, 6, 1, 0, 0);
    outputs_valid  = 2'd0;
    check_cycle("empty");
    check("empty_num_const", 256'(num_retiring), 256'(0));
    advance();

    // Mispredict: retires alone, then one RECOVER cycle.
    rob_outputs[0] = pk(1, 50, 1, 1, 1, 1, 0);
    rob_outputs[1] = pk(1, 51, 9, 2, 1, 0, 0);
    outputs_valid  = 2'd2;
    check_cycle("mis");
    check("mis_num_const", 256'(num_retiring), 256'(1));
    advance();
    check_cycle("recover");
    check("recover_rollback_const", 256'(rollback), 256'(1));
    check("recover_num_const", 256'(num_retiring), 256'(0));
    check("recover_map1_const", 256'(arch_map[1]), 256'(50));
    advance();
    rob_outputs[0] = pk(1, 52, 7, 2, 1, 0, 0);
    rob_outputs[1] = pk(1, 53, 8, 9, 1, 0, 0);
    check_cycle("post_recover");
    check("post_recover_rollback_const", 256'(rollback), 256'(0));
    check("post_recover_num_const", 256'(num_retiring), 256'(2));
    advance();

    // x0 destination and halt.
    rob_outputs[0] = pk(1, 60, 4, 0, 1, 0, 0);
    rob_outputs[1] = pk(1, 0, 0, 0, 0, 0, 1);
    check_cycle("x0_halt");
    check("x0_halt_num_const", 256'(num_retiring), 256'(2));
    check("x0_halt_fv_const", 256'(free_valid), 256'(0));
    advance();
    rob_outputs[0] = pk(1, 61, 12, 10, 1, 0, 0);
    rob_outputs[1] = pk(1, 62, 13, 11, 1, 0, 0);
    check_cycle("halted");
    check("halted_const", 256'(halted), 256'(1));
    check("halted_map0_const", 256'(arch_map[0]), 256'(0));
    for (int k = 0; k < 12; k++) begin
      check_cycle("halt_hold");
      check("halt_hold_num_const", 256'(num_retiring), 256'(0));
      advance();
    end

    // Asynchronous reset mid-cycle while halted.
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_map5", 256'(arch_map[5]), 256'(5));
    check("async_count", 256'(retired_count), 256'(0));
    check("async_halted", 256'(halted), 256'(0));
    check("async_num", 256'(num_retiring), 256'(0));
    @(negedge clock);
    reset = 1'b0;

    halt_cycles = 0;
    for (int c = 0; c < 600; c++) begin
      if (halt_cycles > 3 || $urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        check_cycle("rnd_reset");
        advance();
        reset       = 1'b0;
        halt_cycles = 0;
      end
      rob_outputs[0] = rand_pkt();
      rob_outputs[1] = rand_pkt();
      outputs_valid  = 2'($urandom_range(0, 2));
      check_cycle("rnd");
      advance();
      if (m_halted) halt_cycles++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
